matriz_leds_param: RTL and testbench

Parametrised LED-matrix puzzle engine for the light-toggling game, for an N_ROWS x N_COLS matrix and N_BTNS buttons.
- Each button press toggles a fixed region of cells. The cell-per-button map comes from a parameter, not from hard-coded logic.
- Block synchronises and edge-detects buttons, scans only the rows active for the current level with a programmable dwell, detects the win, and counts moves.
- Sits between the debounced button inputs, the game control unit (which drives `nivel` and consumes the win flags) and the matrix pins.

---
 rtl/matriz_pkg.sv | 29 ++
 rtl/sincroniza_botoes.sv | 32 +++
 rtl/matriz_leds_param.sv | 124 ++++++++++++
 tb/tb_matriz_leds_param.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// matriz_pkg -- shared constants and helpers for the LED-matrix puzzle engine.
//   MAPA_PADRAO      : default 8x8 / 8-button toggle-region map. Each button owns
//                      a 64-bit slice {row7 .. row0}, one byte per row, bit c = column c.
//   N_NIVEIS_PADRAO  : default number of valid levels.
//   linhas_ativas()  : rows scanned for a level, min(2*nivel+1, n_rows).
package matriz_pkg;

  localparam int N_NIVEIS_PADRAO = 5;

  // Buttons 0, 4, 5 and 7 split row 0 into disjoint pieces so level 0 is
  // winnable; the remaining buttons overlap others to make the puzzle non-trivial.
  localparam logic [511:0] MAPA_PADRAO = {
    64'h8080_8080_8080_8080,  // b7: column 7, all rows
    64'hFFFF_0000_0000_0000,  // b6: rows 6-7, all columns
    64'h0000_0000_6060_6060,  // b5: rows 0-3, columns 5-6
    64'h0000_0000_0000_1818,  // b4: rows 0-1, columns 3-4
    64'h0000_003C_3C3C_0000,  // b3: rows 2-4, columns 2-5
    64'h3838_3800_0000_0000,  // b2: rows 5-7, columns 3-5
    64'h0000_0707_0700_0000,  // b1: rows 3-5, columns 0-2
    64'h0000_0000_0007_0707   // b0: rows 0-2, columns 0-2
  };

  function automatic int linhas_ativas(input logic [2:0] nivel, input int n_rows);
    int n;
    n = 2 * int'(nivel) + 1;
    return (n > n_rows) ? n_rows : n;
  endfunction

endpackage

// File: rtl/sincroniza_botoes.sv
// sincroniza_botoes -- two-flop synchroniser and rising-edge detector.
//   clk, rst : system clock, async active-high reset
//   botoes   : raw (debounced, asynchronous) button levels
//   borda    : one-cycle registered pulse per button on each press
// The edge term s2 & ~prev is registered, so a level first sampled at edge k
// yields borda high during the cycle after edge k+2 (consumed at edge k+3).
module sincroniza_botoes #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] botoes,
  output logic [N-1:0] borda
);

  logic [N-1:0] s1, s2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      borda <= '0;
    end else begin
      s1    <= botoes;
      s2    <= s1;
      prev  <= s2;
      borda <= s2 & ~prev;
    end
  end

endmodule

// File: rtl/matriz_leds_param.sv
// matriz_leds_param -- LED-matrix light-toggling puzzle engine.
//   clk, rst        : system clock, async active-high reset
//   botoes          : debounced button levels (asynchronous)
//   nivel           : current level; levels >= N_NIVEIS blank the matrix
//   limpa           : synchronous clear of field and move counter
//   colunas         : active-low column drive for the selected row
//   linhas          : active-high one-hot row select
//   nivel_concluido : registered "all active rows lit" flag
//   vitoria_pulso   : one-cycle pulse on the rise of nivel_concluido
//   jogadas         : accepted-move counter, saturating at 255
module matriz_leds_param
  import matriz_pkg::*;
#(
  parameter int N_ROWS   = 8,
  parameter int N_COLS   = 8,
  parameter int N_BTNS   = 8,
  parameter int N_NIVEIS = N_NIVEIS_PADRAO,
  parameter int SCAN_DIV = 1024,
  parameter logic [N_BTNS*N_ROWS*N_COLS-1:0] MAPA = MAPA_PADRAO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTNS-1:0] botoes,
  input  logic [2:0]        nivel,
  input  logic              limpa,
  output logic [N_COLS-1:0] colunas,
  output logic [N_ROWS-1:0] linhas,
  output logic              nivel_concluido,
  output logic              vitoria_pulso,
  output logic [7:0]        jogadas
);

  localparam int CELLS = N_ROWS * N_COLS;
  localparam int RA_W  = $clog2(N_ROWS + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [N_BTNS-1:0] borda;
  logic [CELLS-1:0]  campo;
  logic [CELLS-1:0]  mascara;
  logic [RA_W-1:0]   rows_ativas;
  logic [RA_W-1:0]   idx;
  logic [DIV_W-1:0]  div_cnt;
  logic              aceita;
  logic              concluido_next;

  sincroniza_botoes #(.N(N_BTNS)) u_sincroniza (
    .clk    (clk),
    .rst    (rst),
    .botoes (botoes),
    .borda  (borda)
  );

  always_comb begin
    rows_ativas = '0;
    if (int'(nivel) < N_NIVEIS)
      rows_ativas = RA_W'(linhas_ativas(nivel, N_ROWS));
  end

  // Regions are XOR-combined so a cell hit by two simultaneous presses
  // toggles twice and ends up unchanged.
  always_comb begin
    mascara = '0;
    for (int b = 0; b < N_BTNS; b++)
      if (borda[b]) mascara = mascara ^ MAPA[b*CELLS +: CELLS];
  end

  assign aceita = (|borda) && !nivel_concluido && !limpa;

  always_comb begin
    concluido_next = (rows_ativas != '0);
    for (int r = 0; r < N_ROWS; r++)
      if ((RA_W'(r) < rows_ativas) && !(&campo[r*N_COLS +: N_COLS]))
        concluido_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      campo           <= '0;
      jogadas         <= '0;
      nivel_concluido <= 1'b0;
      vitoria_pulso   <= 1'b0;
    end else begin
      if (limpa) begin
        campo   <= '0;
        jogadas <= '0;
      end else if (aceita) begin
        campo <= campo ^ mascara;
        if (jogadas != 8'hFF) jogadas <= jogadas + 8'd1;
      end
      nivel_concluido <= concluido_next;
      vitoria_pulso   <= concluido_next & ~nivel_concluido;
    end
  end

  // Row scan. An index left out of range by a level change restarts at row 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      div_cnt <= '0;
    end else if (idx >= rows_ativas) begin
      idx     <= '0;
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == rows_ativas - RA_W'(1)) ? '0 : idx + RA_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    linhas  = '0;
    colunas = '1;
    if (rows_ativas != '0) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if (idx == RA_W'(r)) begin
          linhas[r] = 1'b1;
          colunas   = ~campo[r*N_COLS +: N_COLS];
        end
      end
    end
  end

endmodule

// File: tb/tb_matriz_leds_param.sv
module tb_matriz_leds_param;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] botoes;
  logic [2:0] nivel;
  logic       limpa;
  logic [7:0] colunas;
  logic [7:0] linhas;
  logic       nivel_concluido;
  logic       vitoria_pulso;
  logic [7:0] jogadas;

  matriz_leds_param #(
    .N_ROWS(8), .N_COLS(8), .N_BTNS(8), .N_NIVEIS(5), .SCAN_DIV(SD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .botoes          (botoes),
    .nivel           (nivel),
    .limpa           (limpa),
    .colunas         (colunas),
    .linhas          (linhas),
    .nivel_concluido (nivel_concluido),
    .vitoria_pulso   (vitoria_pulso),
    .jogadas         (jogadas)
  );

  always #5 clk = ~clk;

  // Reference model: region table per button (row bytes 0..7), field rows,
  // move count, win state and number of expected win pulses.
  logic [7:0] mapa_tb [8][8];
  logic [7:0] m_row [8];
  int         m_jog;
  bit         m_win;
  int         m_pulsos;
  int         pulsos;
  int         n_cmp;
  int         n_err;
  int         lat;

  always @(posedge clk) if (vitoria_pulso === 1'b1) pulsos++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ra_of(input int nv);
    if (nv >= 5) return 0;
    return (2 * nv + 1 > 8) ? 8 : 2 * nv + 1;
  endfunction

  function automatic bit win_of();
    int ra;
    ra = ra_of(int'(nivel));
    if (ra == 0) return 1'b0;
    for (int r = 0; r < ra; r++)
      if (m_row[r] != 8'hFF) return 1'b0;
    return 1'b1;
  endfunction

  task automatic update_win();
    bit w;
    w = win_of();
    if (w && !m_win) m_pulsos++;
    m_win = w;
  endtask

  task automatic model_press(input logic [7:0] mask);
    if (mask != 8'h00 && !m_win) begin
      for (int b = 0; b < 8; b++)
        if (mask[b])
          for (int r = 0; r < 8; r++) m_row[r] ^= mapa_tb[b][r];
      if (m_jog < 255) m_jog++;
    end
    update_win();
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) m_row[r] = 8'h00;
    m_jog = 0;
  endtask

  task automatic press(input logic [7:0] mask);
    @(negedge clk);
    botoes = mask;
    repeat (3) @(negedge clk);
    botoes = 8'h00;
    repeat (6) @(negedge clk);
    model_press(mask);
  endtask

  task automatic set_nivel(input int nv);
    @(negedge clk);
    nivel = 3'(nv);
    repeat (4) @(negedge clk);
    update_win();
  endtask

  task automatic do_limpa();
    @(negedge clk);
    limpa = 1'b1;
    @(negedge clk);
    limpa = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    update_win();
  endtask

  // Compares counters and flag, then watches one full scan and checks each
  // lit row against the model.
  task automatic check_state();
    int ra;
    int r;
    logic [7:0] exp_c;
    ra = ra_of(int'(nivel));
    check("jogadas", jogadas, m_jog);
    check("concluido", nivel_concluido, m_win);
    if (ra == 0) begin
      check("linhas_apagadas", linhas, 8'h00);
      check("colunas_apagadas", colunas, 8'hFF);
    end else begin
      repeat (SD * ra + 1) begin
        @(negedge clk);
        r = -1;
        for (int i = 0; i < 8; i++) if (linhas == (8'h01 << i)) r = i;
        check("linha_valida", (r >= 0 && r < ra), 1);
        if (r >= 0) begin
          exp_c = ~m_row[r];
          check("colunas_linha", colunas, exp_c);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] exp_l;
    int wait_cnt;
    mapa_tb = '{
      '{8'h07, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h07, 8'h07, 8'h07, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h38, 8'h38, 8'h38},
      '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00},
      '{8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h60, 8'h60, 8'h60, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF},
      '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80}
    };
    n_cmp = 0; n_err = 0; pulsos = 0; m_pulsos = 0; m_win = 1'b0;
    model_clear();
    rst = 1'b1; botoes = 8'h00; nivel = 3'd0; limpa = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_linhas", linhas, 8'h01);
    check("rst_colunas", colunas, 8'hFF);
    check("rst_jogadas", jogadas, 8'h00);
    check("rst_concluido", nivel_concluido, 1'b0);
    check("rst_pulso", vitoria_pulso, 1'b0);
    rst = 1'b0;

    // Held button toggles once
    @(negedge clk);
    botoes = 8'h01;
    repeat (50) @(negedge clk);
    botoes = 8'h00;
    repeat (3) @(negedge clk);
    model_press(8'h01);
    check("hold_linhas", linhas, 8'h01);
    check("hold_colunas", colunas, 8'hF8);
    check("hold_jogadas", jogadas, 8'd1);
    set_nivel(1);
    check_state();

    // Level 0 win with exact latency and pulse width
    set_nivel(0);
    do_limpa();
    press(8'h01);
    press(8'h10);
    press(8'h20);
    check_state();
    @(negedge clk);
    botoes = 8'h80;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (colunas == 8'h00) lat = i;
    end
    check("latencia_campo", lat, 4);
    check("win_antes", nivel_concluido, 1'b0);
    @(negedge clk);
    check("win_depois", nivel_concluido, 1'b1);
    check("pulso_alto", vitoria_pulso, 1'b1);
    botoes = 8'h00;
    @(negedge clk);
    check("pulso_baixo", vitoria_pulso, 1'b0);
    repeat (4) @(negedge clk);
    model_press(8'h80);
    check("win_pulsos", pulsos, m_pulsos);
    press(8'h01);
    check_state();

    // limpa after a win
    @(negedge clk);
    limpa = 1'b1;
    @(negedge clk);
    limpa = 1'b0;
    check("limpa_jogadas", jogadas, 8'h00);
    check("limpa_colunas", colunas, 8'hFF);
    check("limpa_conc_ainda", nivel_concluido, 1'b1);
    @(negedge clk);
    check("limpa_conc_cai", nivel_concluido, 1'b0);
    model_clear();
    update_win();

    // Simultaneous and overlapping presses (b0 and b3 share cell (2,2))
    set_nivel(4);
    press(8'h09);
    check_state();
    press(8'h03);
    check_state();

    // Scan sequence from reset at level 1
    @(negedge clk);
    nivel = 3'd1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_win = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_l = 8'h01 << ((i / SD) % 3);
      check("scan_seq", linhas, exp_l);
    end
    wait_cnt = 0;
    while (linhas != 8'h04 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("scan_espera_idx2", linhas, 8'h04);
    nivel = 3'd0;
    @(negedge clk);
    check("scan_encolhe", linhas, 8'h01);
    update_win();
    set_nivel(7);
    check("nivel7_linhas", linhas, 8'h00);
    check("nivel7_colunas", colunas, 8'hFF);
    check("nivel7_concluido", nivel_concluido, 1'b0);

    // Asynchronous reset between edges
    set_nivel(1);
    press(8'h20);
    check_state();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_linhas", linhas, 8'h01);
    check("arst_colunas", colunas, 8'hFF);
    check("arst_jogadas", jogadas, 8'h00);
    check("arst_concluido", nivel_concluido, 1'b0);
    check("arst_pulso", vitoria_pulso, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_win = 1'b0;

    // Saturation of the move counter
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      botoes = 8'h80;
      repeat (2) @(negedge clk);
      botoes = 8'h00;
      repeat (2) @(negedge clk);
      model_press(8'h80);
    end
    repeat (6) @(negedge clk);
    check("saturacao", jogadas, 8'd255);
    check_state();

    // Randomised transactions
    do_limpa();
    set_nivel(0);
    for (int t = 0; t < 60; t++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) press(8'($urandom_range(1, 255)));
      else if (sel <= 7) set_nivel(int'($urandom_range(0, 7)));
      else do_limpa();
      check_state();
    end
    repeat (2) @(negedge clk);
    check("total_pulsos", pulsos, m_pulsos);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
